// File: rtl/sc_road_scroll_sequencer.sv
// Road scroll sequencer: on each level-dependent move tick, shifts the 8-row obstacle bank down one row
// and loads a new LFSR-generated row at the top; counts completed scrolls as saturating points.
module sc_road_scroll_sequencer #(
  parameter int unsigned TICK_L1   = 25000000,
  parameter int unsigned TICK_L2   = 15000000,
  parameter int unsigned TICK_L3   = 8000000,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic       SC_STATEMACHINE_GENERAL_CLOCK_50,
  input  logic       SC_STATEMACHINE_GENERAL_RESET_InHigh,
  input  logic       run_InLow,
  input  logic       hold_InLow,
  input  logic       clear_InLow,
  input  logic [1:0] level_InBUS,
  output logic       tick_Out,
  output logic [7:0] regLoad_OutBUS,
  output logic       muxSel_Out,
  output logic [7:0] rowData_OutBUS,
  output logic       busy_Out,
  output logic       done_Out,
  output logic [7:0] points_OutBUS
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_TICK, S_GEN, S_SHIFT, S_LOAD_TOP, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [7:0]  row_q, row_d;
  logic [7:0]  points_q, points_d;

  logic [31:0] period;
  logic [7:0]  lfsr_nxt;
  logic [7:0]  dens;
  logic [7:0]  gapped;
  logic [2:0]  gap_lo;
  logic [2:0]  gap_hi;
  logic        tick_fire;

  always_comb begin
    case (level_InBUS)
      2'd2:    period = 32'(TICK_L2);
      2'd3:    period = 32'(TICK_L3);
      default: period = 32'(TICK_L1);
    endcase
  end

  // Galois right-shift; level 1 thins the pattern by ANDing with its nibble swap
  always_comb begin
    lfsr_nxt = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
    if (level_InBUS == 2'd2 || level_InBUS == 2'd3) begin
      dens = lfsr_nxt;
    end else begin
      dens = lfsr_nxt & {lfsr_nxt[3:0], lfsr_nxt[7:4]};
    end
    gap_lo = lfsr_nxt[2:0];
    gap_hi = gap_lo + 3'd1;
    gapped = dens & ~((8'd1 << gap_lo) | (8'd1 << gap_hi));
  end

  assign tick_fire = (state_q == S_WAIT_TICK) && !run_InLow && hold_InLow && clear_InLow &&
                     (cnt_q == period - 32'd1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    lfsr_d   = lfsr_q;
    row_d    = row_q;
    points_d = points_q;

    if (!clear_InLow) begin
      state_d  = S_IDLE;
      cnt_d    = 32'd0;
      lfsr_d   = LFSR_SEED;
      row_d    = 8'd0;
      points_d = 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d = 32'd0;
          if (!run_InLow) state_d = S_WAIT_TICK;
        end
        S_WAIT_TICK: begin
          if (run_InLow) begin
            state_d = S_IDLE;
            cnt_d   = 32'd0;
          end else if (hold_InLow) begin
            if (tick_fire) begin
              cnt_d   = 32'd0;
              state_d = S_GEN;
            end else begin
              cnt_d = cnt_q + 32'd1;
            end
          end
        end
        S_GEN: begin
          lfsr_d  = lfsr_nxt;
          row_d   = gapped;
          idx_d   = 3'd7;
          state_d = S_SHIFT;
        end
        S_SHIFT: begin
          if (idx_q == 3'd1) state_d = S_LOAD_TOP;
          else idx_d = idx_q - 3'd1;
        end
        S_LOAD_TOP: begin
          // points become visible in the same cycle as done_Out
          if (points_q != 8'hFF) points_d = points_q + 8'd1;
          state_d = S_DONE;
        end
        S_DONE: begin
          state_d = run_InLow ? S_IDLE : S_WAIT_TICK;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge SC_STATEMACHINE_GENERAL_CLOCK_50 or posedge SC_STATEMACHINE_GENERAL_RESET_InHigh) begin
    if (SC_STATEMACHINE_GENERAL_RESET_InHigh) begin
      state_q  <= S_IDLE;
      cnt_q    <= 32'd0;
      idx_q    <= 3'd0;
      lfsr_q   <= LFSR_SEED;
      row_q    <= 8'd0;
      points_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      lfsr_q   <= lfsr_d;
      row_q    <= row_d;
      points_q <= points_d;
    end
  end

  always_comb begin
    regLoad_OutBUS = 8'hFF;
    if (state_q == S_SHIFT)    regLoad_OutBUS = ~(8'd1 << idx_q);
    if (state_q == S_LOAD_TOP) regLoad_OutBUS = 8'hFE;
  end

  assign tick_Out       = tick_fire;
  assign muxSel_Out     = (state_q == S_LOAD_TOP);
  assign busy_Out       = (state_q == S_GEN) || (state_q == S_SHIFT) ||
                          (state_q == S_LOAD_TOP) || (state_q == S_DONE);
  assign done_Out       = (state_q == S_DONE);
  assign rowData_OutBUS = row_q;
  assign points_OutBUS  = points_q;

endmodule

// File: tb/tb_sc_road_scroll_sequencer.sv
// Directed bench for the road scroll sequencer with short tick periods (20/12/6).
module tb_sc_road_scroll_sequencer;

  logic       clk;
  logic       rst;
  logic       run_InLow;
  logic       hold_InLow;
  logic       clear_InLow;
  logic [1:0] level_InBUS;
  logic       tick_Out;
  logic [7:0] regLoad_OutBUS;
  logic       muxSel_Out;
  logic [7:0] rowData_OutBUS;
  logic       busy_Out;
  logic       done_Out;
  logic [7:0] points_OutBUS;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_lfsr;
  logic [7:0] exp_row;
  int         exp_points;

  sc_road_scroll_sequencer #(
    .TICK_L1(20), .TICK_L2(12), .TICK_L3(6), .LFSR_SEED(8'hA5)
  ) dut (
    .SC_STATEMACHINE_GENERAL_CLOCK_50(clk),
    .SC_STATEMACHINE_GENERAL_RESET_InHigh(rst),
    .run_InLow(run_InLow),
    .hold_InLow(hold_InLow),
    .clear_InLow(clear_InLow),
    .level_InBUS(level_InBUS),
    .tick_Out(tick_Out),
    .regLoad_OutBUS(regLoad_OutBUS),
    .muxSel_Out(muxSel_Out),
    .rowData_OutBUS(rowData_OutBUS),
    .busy_Out(busy_Out),
    .done_Out(done_Out),
    .points_OutBUS(points_OutBUS)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {1'b0, s[7:1]} ^ (s[0] ? 8'hB8 : 8'h00);
  endfunction

  function automatic logic [7:0] row_of(input logic [7:0] r, input logic [1:0] lvl);
    logic [7:0] raw;
    logic [2:0] g;
    raw = (lvl == 2'd2 || lvl == 2'd3) ? r : (r & {r[3:0], r[7:4]});
    g = r[2:0];
    raw[g] = 1'b0;
    g = g + 3'd1;
    raw[g] = 1'b0;
    return raw;
  endfunction

  // Counts falling edges until tick_Out is seen; advances the reference model on each tick.
  task automatic wait_tick(input int budget, output int n);
    bit seen;
    seen = 0;
    n = 0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      if (tick_Out === 1'b1) seen = 1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL wait_tick: tick_Out=%b after %0d cycles, required a pulse", tick_Out, budget);
    end else begin
      m_lfsr  = lfsr_step(m_lfsr);
      exp_row = row_of(m_lfsr, level_InBUS);
      if (exp_points < 255) exp_points++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    run_InLow = 1'b1; hold_InLow = 1'b1; clear_InLow = 1'b1; level_InBUS = 2'd1;
    m_lfsr = 8'hA5; exp_row = 8'h00; exp_points = 0;
    repeat (2) @(negedge clk);
    total++; if (regLoad_OutBUS !== 8'hFF) begin bad++; $display("FAIL reset_regload: got %h want ff", regLoad_OutBUS); end
    total++; if (muxSel_Out !== 1'b0) begin bad++; $display("FAIL reset_mux: got %b want 0", muxSel_Out); end
    total++; if (tick_Out !== 1'b0) begin bad++; $display("FAIL reset_tick: got %b want 0", tick_Out); end
    total++; if (done_Out !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done_Out); end
    total++; if (busy_Out !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_Out); end
    total++; if (rowData_OutBUS !== 8'h00) begin bad++; $display("FAIL reset_row: got %h want 00", rowData_OutBUS); end
    total++; if (points_OutBUS !== 8'h00) begin bad++; $display("FAIL reset_points: got %h want 00", points_OutBUS); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Starts right after a tick edge and walks GEN .. DONE and the first WAIT_TICK cycle (11 edges).
  task automatic scroll_check(input logic [7:0] row_const, input bit use_const);
    logic [7:0] want;
    @(negedge clk);
    total++; if (tick_Out !== 1'b0 || busy_Out !== 1'b1 || regLoad_OutBUS !== 8'hFF) begin
      bad++; $display("FAIL gen_cycle: tick=%b busy=%b regload=%h want 0 1 ff", tick_Out, busy_Out, regLoad_OutBUS);
    end
    for (int i = 7; i >= 1; i--) begin
      @(negedge clk);
      want = ~(8'd1 << i);
      total++; if (regLoad_OutBUS !== want || muxSel_Out !== 1'b0) begin
        bad++; $display("FAIL shift_strobe: regload=%h mux=%b want %h 0", regLoad_OutBUS, muxSel_Out, want);
      end
    end
    total++; if (rowData_OutBUS !== (use_const ? row_const : exp_row)) begin
      bad++; $display("FAIL scroll_row: got %h want %h", rowData_OutBUS, use_const ? row_const : exp_row);
    end
    @(negedge clk);
    total++; if (regLoad_OutBUS !== 8'hFE || muxSel_Out !== 1'b1) begin
      bad++; $display("FAIL load_top: regload=%h mux=%b want fe 1", regLoad_OutBUS, muxSel_Out);
    end
    @(negedge clk);
    total++; if (done_Out !== 1'b1 || points_OutBUS !== 8'(exp_points) || regLoad_OutBUS !== 8'hFF) begin
      bad++; $display("FAIL done_cycle: done=%b points=%0d regload=%h want 1 %0d ff", done_Out, points_OutBUS, regLoad_OutBUS, exp_points);
    end
    @(negedge clk);
    total++; if (done_Out !== 1'b0 || busy_Out !== 1'b0) begin
      bad++; $display("FAIL after_done: done=%b busy=%b want 0 0", done_Out, busy_Out);
    end
  endtask

  task automatic test_basic_tick;
    int n;
    run_InLow = 1'b0; level_InBUS = 2'd1;
    wait_tick(100, n);
    total++; if (n != 20) begin bad++; $display("FAIL first_tick: got %0d cycles want 20", n); end
    scroll_check(8'hA2, 1'b1);
    wait_tick(100, n);
    total++; if (n != 30 - 11) begin bad++; $display("FAIL tick_period: got %0d cycles want %0d", n + 11, 30); end
  endtask

  task automatic test_run_drop;
    int ticks;
    @(negedge clk);
    @(negedge clk);
    run_InLow = 1'b1;
    repeat (8) @(negedge clk);
    total++; if (done_Out !== 1'b1 || points_OutBUS !== 8'(exp_points)) begin
      bad++; $display("FAIL run_drop_done: done=%b points=%0d want 1 %0d", done_Out, points_OutBUS, exp_points);
    end
    @(negedge clk);
    total++; if (busy_Out !== 1'b0 || regLoad_OutBUS !== 8'hFF) begin
      bad++; $display("FAIL run_drop_idle: busy=%b regload=%h want 0 ff", busy_Out, regLoad_OutBUS);
    end
    ticks = 0;
    repeat (60) begin
      @(negedge clk);
      if (tick_Out === 1'b1) ticks++;
    end
    total++; if (ticks != 0) begin bad++; $display("FAIL run_drop_noticks: got %0d ticks want 0", ticks); end
  endtask

  task automatic test_level_hold;
    int n;
    int stray;
    level_InBUS = 2'd3; run_InLow = 1'b0;
    wait_tick(100, n);
    total++; if (n != 6) begin bad++; $display("FAIL l3_first_tick: got %0d want 6", n); end
    wait_tick(100, n);
    total++; if (n != 16) begin bad++; $display("FAIL l3_period: got %0d want 16", n); end
    repeat (11) @(negedge clk);
    hold_InLow = 1'b0;
    stray = 0;
    repeat (5) begin
      @(negedge clk);
      if (tick_Out === 1'b1) stray++;
    end
    hold_InLow = 1'b1;
    total++; if (stray != 0) begin bad++; $display("FAIL hold_tick: got %0d ticks while held want 0", stray); end
    wait_tick(100, n);
    total++; if (n != (16 + 5) - (11 + 5)) begin bad++; $display("FAIL hold_delay: got period %0d want 21", n + 16); end
    @(negedge clk);
    level_InBUS = 2'd0;
    wait_tick(100, n);
    total++; if (n != 30 - 1) begin bad++; $display("FAIL level0_period: got %0d want 30", n + 1); end
    repeat (2) @(negedge clk);
    total++; if (rowData_OutBUS !== exp_row) begin bad++; $display("FAIL level0_row: got %h want %h", rowData_OutBUS, exp_row); end
  endtask

  task automatic test_pattern_gap;
    int n;
    logic [2:0] g;
    logic [2:0] g1;
    level_InBUS = 2'd2;
    for (int k = 0; k < 1000; k++) begin
      wait_tick(100, n);
      repeat (2) @(negedge clk);
      g  = m_lfsr[2:0];
      g1 = g + 3'd1;
      total++; if (rowData_OutBUS !== exp_row) begin bad++; $display("FAIL pattern_row: scroll %0d got %h want %h", k, rowData_OutBUS, exp_row); end
      total++; if (rowData_OutBUS[g] !== 1'b0 || rowData_OutBUS[g1] !== 1'b0) begin
        bad++; $display("FAIL pattern_gap: scroll %0d row %h gap bits %0d,%0d not clear", k, rowData_OutBUS, g, g1);
      end
    end
  endtask

  task automatic test_saturation;
    repeat (8) @(negedge clk);
    total++; if (done_Out !== 1'b1 || points_OutBUS !== 8'd255) begin
      bad++; $display("FAIL saturation: done=%b points=%0d want 1 255", done_Out, points_OutBUS);
    end
  endtask

  task automatic test_clear;
    int n;
    wait_tick(100, n);
    repeat (3) @(negedge clk);
    clear_InLow = 1'b0;
    @(negedge clk);
    total++; if (regLoad_OutBUS !== 8'hFF || busy_Out !== 1'b0 || points_OutBUS !== 8'd0 || rowData_OutBUS !== 8'd0 || done_Out !== 1'b0) begin
      bad++; $display("FAIL clear_state: regload=%h busy=%b points=%0d row=%h done=%b want ff 0 0 00 0",
                      regLoad_OutBUS, busy_Out, points_OutBUS, rowData_OutBUS, done_Out);
    end
    clear_InLow = 1'b1;
    m_lfsr = 8'hA5; exp_points = 0;
    wait_tick(100, n);
    total++; if (n != 12) begin bad++; $display("FAIL clear_restart: got %0d want 12", n); end
    repeat (2) @(negedge clk);
    total++; if (rowData_OutBUS !== 8'hE2) begin bad++; $display("FAIL clear_reseed: got %h want e2", rowData_OutBUS); end
  endtask

  task automatic test_reset_mid_scroll;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (regLoad_OutBUS !== 8'hFF || busy_Out !== 1'b0 || rowData_OutBUS !== 8'h00 || muxSel_Out !== 1'b0 || points_OutBUS !== 8'h00) begin
      bad++; $display("FAIL reset_mid_scroll: regload=%h busy=%b row=%h mux=%b points=%0d want ff 0 00 0 0",
                      regLoad_OutBUS, busy_Out, rowData_OutBUS, muxSel_Out, points_OutBUS);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic_tick();
    test_run_drop();
    test_level_hold();
    test_pattern_gap();
    test_saturation();
    test_clear();
    test_reset_mid_scroll();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
